// File: rtl/eth_mac_project_top.sv
// eth_mac_project_top
//   RGMII store-and-forward loopback for PHY bring-up at 10 Mb/s class rates.
//   One frame is captured from the RX pins into a byte buffer. After it has been
//   received completely and cleanly, the identical byte stream is replayed on the
//   TX pins. Everything runs in the i_clk domain. RX pins are oversampled, and txc
//   is produced by dividing i_clk.
//
//   Parameters
//     TXC_HALF   i_clk cycles per txc half-period (even, >= 2)
//     BUF_BYTES  frame buffer depth in bytes; longer frames are dropped
//     IFG_BYTES  minimum idle byte-times on TX between frames
//
//   Ports
//     i_clk            system clock, sole clock domain
//     i_reset_n        synchronous active-low reset
//     rgmii_phy_rxc    PHY RX clock, sampled as data
//     rgmii_phy_rxd    RX nibble: low nibble at rxc rise, high nibble at rxc fall
//     rgmii_phy_rxctl  RX_DV at rxc rise, RX_DV^RX_ER at rxc fall
//     rgmii_phy_txc    generated TX clock
//     rgmii_phy_txd    TX nibble: low nibble around txc rise, high nibble around txc fall
//     rgmii_phy_txctl  TX_EN, high for the whole frame
module eth_mac_project_top #(
    parameter int unsigned TXC_HALF  = 20,
    parameter int unsigned BUF_BYTES = 2048,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       rgmii_phy_rxc,
    input  logic [3:0] rgmii_phy_rxd,
    input  logic       rgmii_phy_rxctl,
    output logic       rgmii_phy_txc,
    output logic [3:0] rgmii_phy_txd,
    output logic       rgmii_phy_txctl
);

    localparam int unsigned AW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
    localparam int unsigned PW = $clog2(BUF_BYTES + 1);
    localparam int unsigned DW = (TXC_HALF > 1) ? $clog2(TXC_HALF) : 1;
    localparam int unsigned CW = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DONE} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_IFG}  tx_state_t;

    // ---------------- RX synchronisers and nibble assembly ----------------
    logic       r_rxc_s1, r_rxc_s2, r_rxc_s3;
    logic [3:0] r_rxd_s1, r_rxd_s2;
    logic       r_ctl_s1, r_ctl_s2;
    logic       w_rxc_rise, w_rxc_fall;

    logic [3:0] r_lo;
    logic       r_dv;
    logic       r_rise_seen;
    logic [7:0] r_byte;
    logic       r_byte_vld;
    logic       r_byte_dv;
    logic       r_byte_er;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rxc_s1 <= 1'b0;
            r_rxc_s2 <= 1'b0;
            r_rxc_s3 <= 1'b0;
            r_rxd_s1 <= '0;
            r_rxd_s2 <= '0;
            r_ctl_s1 <= 1'b0;
            r_ctl_s2 <= 1'b0;
        end else begin
            r_rxc_s1 <= rgmii_phy_rxc;
            r_rxc_s2 <= r_rxc_s1;
            r_rxc_s3 <= r_rxc_s2;
            r_rxd_s1 <= rgmii_phy_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_ctl_s1 <= rgmii_phy_rxctl;
            r_ctl_s2 <= r_ctl_s1;
        end
    end

    // Data takes the same two-flop path as rxc, so it is sampled with the same
    // delay as the edge it belongs to.
    always_comb begin
        w_rxc_rise = r_rxc_s2 & ~r_rxc_s3;
        w_rxc_fall = ~r_rxc_s2 & r_rxc_s3;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_lo        <= '0;
            r_dv        <= 1'b0;
            r_rise_seen <= 1'b0;
            r_byte      <= '0;
            r_byte_vld  <= 1'b0;
            r_byte_dv   <= 1'b0;
            r_byte_er   <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            if (w_rxc_rise) begin
                r_lo        <= r_rxd_s2;
                r_dv        <= r_ctl_s2;
                r_rise_seen <= 1'b1;
            end else if (w_rxc_fall && r_rise_seen) begin
                r_byte     <= {r_rxd_s2, r_lo};
                r_byte_dv  <= r_dv;
                r_byte_er  <= r_dv ^ r_ctl_s2;
                r_byte_vld <= 1'b1;
            end
        end
    end

    // ---------------- RX FSM and buffer write ----------------
    rx_state_t       r_rx_state;
    logic [PW-1:0]   r_wr_ptr;
    logic            r_rx_bad;
    logic            r_full;
    logic [PW-1:0]   r_len;
    logic            w_rx_byte;
    logic            w_wr_en;
    logic            w_commit;
    logic            w_tx_free;

    // A frame that starts while the buffer is occupied is marked bad at its first
    // byte and never written, so the pending frame cannot be corrupted.
    always_comb begin
        w_rx_byte = r_byte_vld && r_byte_dv &&
                    ((r_rx_state == RX_IDLE) || (r_rx_state == RX_RECV));
        w_wr_en   = 1'b0;
        if (w_rx_byte && !r_byte_er) begin
            if (r_rx_state == RX_IDLE)
                w_wr_en = !r_full;
            else
                w_wr_en = !r_rx_bad && (r_wr_ptr != PW'(BUF_BYTES));
        end
        w_commit  = (r_rx_state == RX_DONE) && !r_rx_bad && (r_wr_ptr != '0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rx_state <= RX_IDLE;
            r_wr_ptr   <= '0;
            r_rx_bad   <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_byte) begin
                        r_rx_state <= RX_RECV;
                        r_rx_bad   <= !w_wr_en;
                        if (w_wr_en)
                            r_wr_ptr <= r_wr_ptr + PW'(1);
                    end
                end
                RX_RECV: begin
                    if (w_rxc_rise && !r_ctl_s2) begin
                        r_rx_state <= RX_DONE;
                    end else if (w_rx_byte) begin
                        // A byte that cannot be stored means ER, overflow or a dropped frame.
                        if (w_wr_en)
                            r_wr_ptr <= r_wr_ptr + PW'(1);
                        else
                            r_rx_bad <= 1'b1;
                    end
                end
                RX_DONE: begin
                    r_rx_state <= RX_IDLE;
                    r_wr_ptr   <= '0;
                    r_rx_bad   <= 1'b0;
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Free is applied before commit so a same-cycle commit wins.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_full <= 1'b0;
            r_len  <= '0;
        end else begin
            if (w_tx_free)
                r_full <= 1'b0;
            if (w_commit) begin
                r_full <= 1'b1;
                r_len  <= r_wr_ptr;
            end
        end
    end

    logic [7:0]    r_mem [BUF_BYTES];
    logic [7:0]    r_rd_byte;
    logic [PW-1:0] r_rd_ptr;

    always_ff @(posedge i_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[AW-1:0]] <= r_byte;
        r_rd_byte <= r_mem[r_rd_ptr[AW-1:0]];
    end

    // ---------------- TX divider and FSM ----------------
    tx_state_t     r_tx_state;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_ifg_cnt;
    logic          r_txc;
    logic [3:0]    r_txd;
    logic          r_txctl;
    logic          w_edge;
    logic          w_mid;

    // w_mid fires TXC_HALF/2 cycles before the next txc edge; r_txc tells which
    // edge is coming (0: rise, low nibble; 1: fall, high nibble).
    always_comb begin
        w_edge    = (r_div == DW'(TXC_HALF - 1));
        w_mid     = (r_div == DW'(TXC_HALF - 1 - TXC_HALF / 2));
        w_tx_free = (r_tx_state == TX_IFG) && w_mid && !r_txc &&
                    (r_ifg_cnt == CW'(IFG_BYTES - 1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_div      <= '0;
            r_txc      <= 1'b0;
            r_txd      <= '0;
            r_txctl    <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_rd_ptr   <= '0;
            r_ifg_cnt  <= '0;
        end else begin
            if (w_edge) begin
                r_div <= '0;
                r_txc <= ~r_txc;
            end else begin
                r_div <= r_div + DW'(1);
            end

            if (w_mid) begin
                case (r_tx_state)
                    TX_IDLE: begin
                        if (!r_txc && r_full) begin
                            r_txctl    <= 1'b1;
                            r_txd      <= r_rd_byte[3:0];
                            r_tx_state <= TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        if (r_txc) begin
                            r_txd    <= r_rd_byte[7:4];
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                        end else if (r_rd_ptr == r_len) begin
                            r_txctl    <= 1'b0;
                            r_txd      <= '0;
                            r_tx_state <= TX_IFG;
                            r_ifg_cnt  <= '0;
                        end else begin
                            r_txd <= r_rd_byte[3:0];
                        end
                    end
                    TX_IFG: begin
                        if (!r_txc) begin
                            if (r_ifg_cnt == CW'(IFG_BYTES - 1)) begin
                                r_tx_state <= TX_IDLE;
                                r_rd_ptr   <= '0;
                            end else begin
                                r_ifg_cnt <= r_ifg_cnt + CW'(1);
                            end
                        end
                    end
                    default: begin
                        r_tx_state <= TX_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rgmii_phy_txc   = r_txc;
        rgmii_phy_txd   = r_txd;
        rgmii_phy_txctl = r_txctl;
    end

endmodule

// File: tb/tb_eth_mac_project_top.sv
module tb_eth_mac_project_top;

    localparam int TXC_HALF = 4;
    localparam int BUF      = 128;
    localparam int IFG      = 12;

    logic       i_clk     = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       rxc       = 1'b0;
    logic [3:0] rxd       = 4'h0;
    logic       rxctl     = 1'b0;
    logic       txc;
    logic [3:0] txd;
    logic       txctl;

    eth_mac_project_top #(
        .TXC_HALF (TXC_HALF),
        .BUF_BYTES(BUF),
        .IFG_BYTES(IFG)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .rgmii_phy_rxc  (rxc),
        .rgmii_phy_rxd  (rxd),
        .rgmii_phy_rxctl(rxctl),
        .rgmii_phy_txc  (txc),
        .rgmii_phy_txd  (txd),
        .rgmii_phy_txctl(txctl)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int len;
        int kind;
        int seed;
        int er_idx;
        int echo;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] a_q[$];
    logic [7:0] cur_q[$];
    logic [7:0] last_q[$];

    // TX monitor state
    int         got_n       = 0;
    int         gap_viol    = 0;
    int         inframe_gap = 0;
    int         idle_rises  = 0;
    int         cur_rises   = 0;
    int         last_rises  = 0;
    bit         in_frame    = 0;
    bit         have_prev   = 0;
    bit         prev_txc    = 0;
    logic [3:0] lo_nib      = 4'h0;

    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            in_frame   = 0;
            have_prev  = 0;
            idle_rises = 0;
            prev_txc   = 0;
        end else begin
            if (txc && !prev_txc) begin
                if (txctl) begin
                    if (!in_frame) begin
                        if (have_prev && idle_rises < IFG)
                            gap_viol++;
                        in_frame  = 1;
                        cur_rises = 0;
                        cur_q.delete();
                    end
                    cur_rises++;
                    lo_nib = txd;
                end else begin
                    if (in_frame) begin
                        in_frame   = 0;
                        last_q     = cur_q;
                        last_rises = cur_rises;
                        got_n++;
                        have_prev  = 1;
                        idle_rises = 0;
                    end
                    idle_rises++;
                end
            end else if (!txc && prev_txc && in_frame) begin
                if (txctl)
                    cur_q.push_back({txd, lo_nib});
                else
                    inframe_gap++;
            end
            prev_txc = txc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int required);
        n_vec++;
        if (actual != required) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic check_echo(input string name);
        int diffs = 0;
        check({name, " length"}, last_q.size(), exp_q.size());
        check({name, " txctl periods"}, last_rises, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= last_q.size() || last_q[i] !== exp_q[i])
                diffs++;
        check({name, " byte diffs"}, diffs, 0);
    endtask

    task automatic build_frame(input int len, input int kind, input int seed);
        logic [7:0] fcs[4];
        fcs = '{8'h1C, 8'hDF, 8'h44, 8'h21};
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 7)                     exp_q.push_back(8'h55);
            else if (i == 7)               exp_q.push_back(8'hD5);
            else if (kind == 1 && i >= len - 4) exp_q.push_back(fcs[i - (len - 4)]);
            else if (kind == 1)            exp_q.push_back(8'(i - 8));
            else                           exp_q.push_back(8'(seed + i * 13));
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic dv, input logic er);
        rxd = b[3:0]; rxctl = dv;      step(2);
        rxc = 1'b1;                    step(2);
        rxd = b[7:4]; rxctl = dv ^ er; step(2);
        rxc = 1'b0;                    step(2);
    endtask

    task automatic send_frame(input int er_idx);
        for (int i = 0; i < exp_q.size(); i++)
            drive_byte(exp_q[i], 1'b1, (i == er_idx));
        for (int i = 0; i < 3; i++)
            drive_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (got_n >= target) ok = 1;
            else step(1);
        end
    endtask

    task automatic wait_txctl(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (txctl === 1'b1) ok = 1;
            else step(1);
        end
    endtask

    initial begin
        vec_t vecs[11];
        int   base;
        int   bad_cyc;
        bit   ok;
        string nm;

        vecs[0]  = '{76,      1, 0,   -1, 1};  // preamble, SFD, 00..3F, FCS
        vecs[1]  = '{60,      0, 3,   -1, 1};
        vecs[2]  = '{97,      0, 41,  -1, 1};
        vecs[3]  = '{BUF,     0, 77,  -1, 1};  // exactly fills the buffer
        vecs[4]  = '{64,      0, 5,   -1, 1};
        vecs[5]  = '{111,     0, 200, -1, 1};
        vecs[6]  = '{64,      0, 9,   20, 0};  // RX_ER on byte 20
        vecs[7]  = '{64,      0, 17,  -1, 1};
        vecs[8]  = '{BUF + 1, 0, 23,  -1, 0};  // overflow
        vecs[9]  = '{64,      0, 31,  -1, 1};
        vecs[10] = '{1,       0, 0,   -1, 1};  // shortest committable frame

        // Reset held for 100 cycles: outputs stay at zero.
        bad_cyc = 0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (txc !== 1'b0 || txd !== 4'h0 || txctl !== 1'b0)
                bad_cyc++;
        end
        check("reset hold nonzero cycles", bad_cyc, 0);
        i_reset_n = 1'b1;
        step(20);

        for (int v = 0; v < 11; v++) begin
            nm = $sformatf("vec%0d", v);
            build_frame(vecs[v].len, vecs[v].kind, vecs[v].seed);
            base = got_n;
            send_frame(vecs[v].er_idx);
            wait_frames(base + 1, vecs[v].len * 8 + 300, ok);
            check({nm, " echo count"}, got_n - base, vecs[v].echo);
            if (vecs[v].echo != 0 && got_n > base)
                check_echo(nm);
            step(250);
        end

        // Busy drop: a second frame received while the first is transmitting.
        build_frame(40, 0, 7);
        a_q  = exp_q;
        base = got_n;
        send_frame(-1);
        wait_txctl(200, ok);
        check("busy tx started", ok, 1);
        build_frame(20, 0, 99);
        send_frame(-1);
        exp_q = a_q;
        wait_frames(base + 1, 1000, ok);
        step(600);
        check("busy echo count", got_n - base, 1);
        check_echo("busy first");
        build_frame(30, 0, 3);
        base = got_n;
        send_frame(-1);
        wait_frames(base + 1, 30 * 8 + 300, ok);
        check("after busy echo count", got_n - base, 1);
        check_echo("after busy");
        step(250);

        // Reset in the middle of a transmitted frame.
        build_frame(40, 0, 11);
        send_frame(-1);
        wait_txctl(200, ok);
        check("rst tx active", ok, 1);
        i_reset_n = 1'b0;
        step(1);
        check("rst outputs at once", int'({txc, txd, txctl}), 0);
        step(10);
        i_reset_n = 1'b1;
        step(50);
        build_frame(50, 0, 21);
        base = got_n;
        send_frame(-1);
        wait_frames(base + 1, 50 * 8 + 300, ok);
        check("post rst echo count", got_n - base, 1);
        check_echo("post rst");
        step(250);

        check("ifg violations", gap_viol, 0);
        check("txctl low inside frame", inframe_gap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
